pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
Parametrised pipeline stage register that replaces the plain enable-gated stage registers between pipeline stages. It carries a PAYLOAD_W-bit bundle with a valid/ready handshake and a 2-entry skid buffer. The skid buffer lets back-pressure be registered without losing data or throughput. Synchronous flush turns the stage into a bubble, and an optional mode zeroes the payload whenever the stage holds no valid data.

Parameters:
PAYLOAD_W, 32, width of the payload bundle (stage data + control fields, packed by the instantiating stage)
CLEAR_ON_BUBBLE, 1, 1: out_data_o forced to 0 when out_valid_o=0; 0: out_data_o holds last value
RESET_VAL, '0, PAYLOAD_W-bit value loaded into both entries on reset

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-high reset
flush_i  input  1  synchronous kill of all held entries
in_valid_i  input  1  upstream payload valid
in_data_i  input  PAYLOAD_W  upstream payload
in_ready_o  output  1  stage can accept this cycle (registered, no comb path from out_ready_i)
out_valid_o  output  1  downstream payload valid (registered)
out_data_o  output  PAYLOAD_W  downstream payload (registered)
out_ready_i  input  1  downstream accepts this cycle
count_o  output  2  occupancy 0..2

Behaviour:
- Handshake terms:
  - acc = in_valid_i & in_ready_o
  - tak = out_valid_o & out_ready_i
- Storage: main entry (drives out_*) and skid entry. State is EMPTY (0), ONE (main full), or TWO (main + skid full).
- Reset (rst_i high, async): state EMPTY; main = skid = RESET_VAL; out_valid_o=0; out_data_o=RESET_VAL (0 if CLEAR_ON_BUBBLE=1); in_ready_o=1; count_o=0. Reset asserted mid-transfer drops all entries; no partial payload survives.
- Derived outputs:
  - in_ready_o = (state != TWO).
  - out_valid_o = (state != EMPTY).
  - count_o = state encoding.
- Transitions at the rising edge, flush_i=0:
  - EMPTY: acc -> ONE, main<=in_data_i; else stay.
  - ONE:
    - acc & tak -> ONE, main<=in_data_i.
    - acc & !tak -> TWO, skid<=in_data_i.
    - !acc & tak -> EMPTY.
    - neither -> hold.
  - TWO: no acc possible. tak -> ONE, main<=skid. !tak -> hold, both entries unchanged.
- Flush: flush_i=1 at an edge forces EMPTY regardless of acc/tak. A same-cycle input is discarded even though in_ready_o was 1; upstream treats it as consumed. With CLEAR_ON_BUBBLE=1, main is zeroed.
- Latency and throughput: 1 cycle in->out; sustained 1 transfer/cycle when out_ready_i=1.
- Ordering: strict FIFO. Payloads are never duplicated, and are dropped only by flush or reset.
- Stall stability: while out_valid_o=1 and out_ready_i=0, out_data_o is stable.
- CLEAR_ON_BUBBLE=1: out_data_o = 0 whenever out_valid_o=0, including after a drain to EMPTY.
- Width: payload is copied verbatim with no arithmetic. count_o never exceeds 2.

Test Plan:
- Reset then idle: rst_i pulse while in_valid_i=1, in_data_i=32'hDEADBEEF -> out_valid_o=0, out_data_o=0, count_o=0, in_ready_o=1 throughout reset. The first edge after release captures DEADBEEF; out_valid_o=1 the following cycle.
- Streaming: out_ready_i=1, in_valid_i=1 with data 1,2,3,4 on consecutive edges -> out_data_o shows 1,2,3,4 one cycle later each, count_o=1 steady, in_ready_o never drops.
- Back-pressure fill: out_ready_i=0, push 0xA then 0xB -> count_o=2, in_ready_o=0, out_data_o=0xA held. Then out_ready_i=1 -> outputs 0xA then 0xB on successive cycles, count_o 2->1->0, in_ready_o=1 after the first take.
- Flush with simultaneous push: state TWO (0xA, 0xB), flush_i=1 and in_valid_i=1 data 0xC on the same edge -> next cycle count_o=0, out_valid_o=0, out_data_o=0. 0xC never appears.
- Bubble hold mode (CLEAR_ON_BUBBLE=0): push 0x55, take it, stay idle -> out_valid_o=0, out_data_o remains 0x55. The same sequence with CLEAR_ON_BUBBLE=1 gives out_data_o=0.
- Async reset mid-stall: state TWO, assert rst_i between clock edges -> out_valid_o falls immediately without waiting for a clock edge. After release, no stale 0xA/0xB are emitted.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline stage register with a valid/ready handshake and a
// 2-entry skid buffer. in_ready_o is a function of registered state only, so
// back-pressure never forms a combinational path from out_ready_i upstream.
// flush_i kills every held entry at the next edge. With CLEAR_ON_BUBBLE the
// payload reads as zero whenever the stage is empty.
module pipe_skid_reg #(
    parameter int                   PAYLOAD_W       = 32,
    parameter bit                   CLEAR_ON_BUBBLE = 1'b1,
    parameter logic [PAYLOAD_W-1:0] RESET_VAL       = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    input  logic [PAYLOAD_W-1:0] in_data_i,
    output logic                 in_ready_o,
    output logic                 out_valid_o,
    output logic [PAYLOAD_W-1:0] out_data_o,
    input  logic                 out_ready_i,
    output logic [1:0]           count_o
);

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PAYLOAD_W-1:0] main_q, main_d;
    logic [PAYLOAD_W-1:0] skid_q, skid_d;
    logic                 acc, tak;

    assign in_ready_o  = (state_q != TWO);
    assign out_valid_o = (state_q != EMPTY);
    assign count_o     = state_q;
    // Gating on state_q keeps the output a pure function of registers.
    assign out_data_o  = (CLEAR_ON_BUBBLE && state_q == EMPTY) ? '0 : main_q;

    assign acc = in_valid_i & in_ready_o;
    assign tak = out_valid_o & out_ready_i;

    // Next-state and entry updates; a flush overrides any same-cycle accept/take.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
            // The same-cycle input is dropped on purpose: upstream treats it as consumed.
            if (CLEAR_ON_BUBBLE) main_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        main_d  = in_data_i;
                    end
                end
                ONE: begin
                    if (acc && tak) begin
                        main_d = in_data_i;
                    end else if (acc) begin
                        state_d = TWO;
                        skid_d  = in_data_i;
                    end else if (tak) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready_o is low here, so only a take can move the state.
                    if (tak) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and entry registers; an async reset drops everything held.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg. Two instances share one stimulus stream:
// u_dut clears its payload on bubbles, u_hold keeps the last payload and
// uses a nonzero reset value.
module tb_pipe_skid_reg;

    localparam int          W      = 32;
    localparam logic [31:0] HOLD_R = 32'h0000_1234;

    logic         clk_i = 1'b0;
    logic         rst_i, flush_i, in_valid_i, out_ready_i;
    logic [W-1:0] in_data_i;
    logic         in_ready_o, out_valid_o;
    logic [W-1:0] out_data_o;
    logic [1:0]   count_o;
    logic         h_in_ready, h_out_valid;
    logic [W-1:0] h_out_data;
    logic [1:0]   h_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    pipe_skid_reg #(.PAYLOAD_W(W), .CLEAR_ON_BUBBLE(1'b1), .RESET_VAL('0)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o),
        .out_ready_i(out_ready_i), .count_o(count_o)
    );

    pipe_skid_reg #(.PAYLOAD_W(W), .CLEAR_ON_BUBBLE(1'b0), .RESET_VAL(HOLD_R)) u_hold (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(h_in_ready),
        .out_valid_o(h_out_valid), .out_data_o(h_out_data),
        .out_ready_i(out_ready_i), .count_o(h_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full check of the clearing instance.
    task automatic chk_all(input string tag, input logic v, input logic [31:0] d,
                           input logic [1:0] c, input logic r);
        chk({tag, ".valid"}, {31'd0, out_valid_o}, {31'd0, v});
        chk({tag, ".data"},  out_data_o, d);
        chk({tag, ".count"}, {30'd0, count_o}, {30'd0, c});
        chk({tag, ".ready"}, {31'd0, in_ready_o}, {31'd0, r});
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b1;
        in_data_i = 32'hDEAD_BEEF; out_ready_i = 1'b0;

        // Reset with an upstream push pending: nothing is captured.
        #3;
        chk_all("rst0", 1'b0, 32'h0, 2'd0, 1'b1);
        chk("rst0.hold_data", h_out_data, HOLD_R);
        step();
        chk_all("rst1", 1'b0, 32'h0, 2'd0, 1'b1);
        step();
        chk_all("rst2", 1'b0, 32'h0, 2'd0, 1'b1);
        rst_i = 1'b0;

        // First edge after release captures the pending payload.
        step();
        chk_all("first", 1'b1, 32'hDEAD_BEEF, 2'd1, 1'b1);
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        step();
        chk_all("drain0", 1'b0, 32'h0, 2'd0, 1'b1);
        chk("drain0.hold_data", h_out_data, 32'hDEAD_BEEF);

        // Streaming at one transfer per cycle.
        in_valid_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data_i = 32'(i);
            step();
            chk_all($sformatf("stream%0d", i), 1'b1, 32'(i), 2'd1, 1'b1);
        end
        in_valid_i = 1'b0;
        step();
        chk_all("stream_end", 1'b0, 32'h0, 2'd0, 1'b1);
        chk("stream_end.hold_data", h_out_data, 32'h4);

        // Back-pressure fills the skid entry.
        out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'hA;
        step();
        chk_all("bp_a", 1'b1, 32'hA, 2'd1, 1'b1);
        in_data_i = 32'hB;
        step();
        chk_all("bp_b", 1'b1, 32'hA, 2'd2, 1'b0);
        in_valid_i = 1'b0;
        step();
        chk_all("bp_stall", 1'b1, 32'hA, 2'd2, 1'b0);
        out_ready_i = 1'b1;
        step();
        chk_all("bp_take1", 1'b1, 32'hB, 2'd1, 1'b1);
        step();
        chk_all("bp_take2", 1'b0, 32'h0, 2'd0, 1'b1);

        // Flush from TWO with a simultaneous push: 0xC is discarded.
        out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'hA;
        step();
        in_data_i = 32'hB;
        step();
        chk_all("fl_full", 1'b1, 32'hA, 2'd2, 1'b0);
        flush_i = 1'b1; in_data_i = 32'hC;
        step();
        chk_all("flush", 1'b0, 32'h0, 2'd0, 1'b1);
        chk("flush.hold_valid", {31'd0, h_out_valid}, 32'd0);
        chk("flush.hold_data", h_out_data, 32'hA);
        flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        step();
        chk_all("post_flush", 1'b0, 32'h0, 2'd0, 1'b1);
        chk("post_flush.hold_valid", {31'd0, h_out_valid}, 32'd0);

        // Bubble behaviour: clear vs hold.
        in_valid_i = 1'b1; in_data_i = 32'h55;
        step();
        chk_all("bub_push", 1'b1, 32'h55, 2'd1, 1'b1);
        in_valid_i = 1'b0;
        step();
        chk_all("bub_idle1", 1'b0, 32'h0, 2'd0, 1'b1);
        chk("bub_idle1.hold_data", h_out_data, 32'h55);
        step();
        chk_all("bub_idle2", 1'b0, 32'h0, 2'd0, 1'b1);
        chk("bub_idle2.hold_data", h_out_data, 32'h55);
        chk("bub_idle2.hold_count", {30'd0, h_count}, 32'd0);

        // Async reset while stalled in TWO, asserted between edges.
        out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'hA;
        step();
        in_data_i = 32'hB;
        step();
        in_valid_i = 1'b0;
        chk_all("ar_full", 1'b1, 32'hA, 2'd2, 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        chk_all("ar_async", 1'b0, 32'h0, 2'd0, 1'b1);
        chk("ar_async.hold_valid", {31'd0, h_out_valid}, 32'd0);
        chk("ar_async.hold_data", h_out_data, HOLD_R);
        chk("ar_async.hold_ready", {31'd0, h_in_ready}, 32'd1);
        @(negedge clk_i);
        rst_i = 1'b0; out_ready_i = 1'b1;
        step();
        chk_all("ar_post1", 1'b0, 32'h0, 2'd0, 1'b1);
        chk("ar_post1.hold_data", h_out_data, HOLD_R);
        step();
        chk_all("ar_post2", 1'b0, 32'h0, 2'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
